// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP classifier front end: frame geometry,
// quantized feature / packed vector types and the packer FSM states.
package mlp_pkg;

  localparam int N_FEAT = 6;
  localparam int ACT_W  = 4;

  typedef logic [ACT_W-1:0]        feat_q_t;
  typedef logic [N_FEAT*ACT_W-1:0] mlp_vec_t;

  typedef enum logic {
    COLLECT,
    DROP
  } state_t;

endpackage

// File: rtl/mlp_feat_quant.sv
// Combinational quantizer: optional round-half-up, right shift down to ACT_W
// bits, then saturate so an overflowing round cannot wrap to zero.
module mlp_feat_quant #(
  parameter int IN_W  = 8,
  parameter int ACT_W = 4,
  parameter int ROUND = 1
) (
  input  logic [IN_W-1:0]  din,
  output logic [ACT_W-1:0] q
);

  localparam int SH   = IN_W - ACT_W;
  localparam int RND  = (ROUND != 0 && SH > 0) ? (1 << ((SH > 0) ? SH - 1 : 0)) : 0;
  localparam int MAXQ = (1 << ACT_W) - 1;

  // One extra bit keeps the rounding carry from 0xFF-style inputs visible.
  logic [IN_W:0] sum;
  logic [IN_W:0] shifted;

  assign sum     = {1'b0, din} + (IN_W+1)'(RND);
  assign shifted = sum >> SH;
  assign q       = (shifted > (IN_W+1)'(MAXQ)) ? ACT_W'(MAXQ) : shifted[ACT_W-1:0];

endmodule

// File: rtl/mlp_feature_packer.sv
// Collects N_FEAT quantized features per frame into one flat vector for the
// classifier; one pending slot behind the output register absorbs back-pressure.
module mlp_feature_packer
  import mlp_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ROUND = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output mlp_vec_t         m_inp,
  output logic             err_short,
  output logic             err_long,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int              IDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  mlp_vec_t         asm_reg, frame_vec, pend_reg, out_reg;
  logic             pend_full;
  logic             beat, handoff, frame_done, short_nxt, long_nxt;
  feat_q_t          q;

  mlp_feat_quant #(
    .IN_W (IN_W),
    .ACT_W(ACT_W),
    .ROUND(ROUND)
  ) u_quant (
    .din(s_data),
    .q  (q)
  );

  assign s_ready = rst_n & ~pend_full;
  assign beat    = s_valid & s_ready;
  assign handoff = m_valid & m_ready;
  assign m_inp   = out_reg;

  // frame_vec is the assembly register with the current beat merged in, so a
  // completing beat can be handed off without first landing in asm_reg.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    frame_done = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    frame_vec  = asm_reg;
    frame_vec[int'(idx)*ACT_W +: ACT_W] = q;
    if (beat) begin
      case (state)
        COLLECT: begin
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (s_last) begin
              frame_done = 1'b1;
            end else begin
              long_nxt  = 1'b1;
              state_nxt = DROP;
            end
          end else if (s_last) begin
            short_nxt = 1'b1;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
        DROP: begin
          if (s_last) begin
            state_nxt = COLLECT;
            idx_nxt   = '0;
          end
        end
        default: state_nxt = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      err_short <= short_nxt;
      err_long  <= long_nxt;
    end
  end

  // A completing frame goes straight to the output when it is free or being
  // drained this cycle; pending is never full then because s_ready is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_reg   <= '0;
      pend_reg  <= '0;
      pend_full <= 1'b0;
      out_reg   <= '0;
      m_valid   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (beat && state == COLLECT) asm_reg <= frame_vec;
      if (handoff) frame_cnt <= frame_cnt + CNT_W'(1);
      if (frame_done && (!m_valid || m_ready)) begin
        out_reg <= frame_vec;
        m_valid <= 1'b1;
      end else if (frame_done) begin
        pend_reg  <= frame_vec;
        pend_full <= 1'b1;
      end else if (handoff) begin
        if (pend_full) begin
          out_reg   <= pend_reg;
          pend_full <= 1'b0;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mlp_feature_packer.sv
// Directed bench for mlp_feature_packer: a frame-level queue model checked
// every cycle, plus literal vector values for the documented scenarios.
module tb_mlp_feature_packer;
  import mlp_pkg::*;

  localparam int IN_W    = 8;
  localparam int ROUND_P = 1;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [IN_W-1:0]  s_data = '0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  mlp_vec_t         m_inp;
  logic             err_short, err_long;
  logic [CNT_W-1:0] frame_cnt;
  logic [IN_W-1:0]  tq_in = '0;
  logic [ACT_W-1:0] tq_out;

  always #5 clk = ~clk;

  mlp_feature_packer #(.IN_W(IN_W), .ROUND(ROUND_P), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_inp(m_inp), .err_short(err_short), .err_long(err_long), .frame_cnt(frame_cnt)
  );

  mlp_feat_quant #(.IN_W(IN_W), .ACT_W(ACT_W), .ROUND(0)) u_trunc (
    .din(tq_in), .q(tq_out)
  );

  int vec_cnt = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int quant(input int raw);
    int sh = IN_W - ACT_W;
    int v  = raw;
    if (ROUND_P != 0 && sh > 0) v += (1 << (sh - 1));
    v = v >> sh;
    if (v > (1 << ACT_W) - 1) v = (1 << ACT_W) - 1;
    return v;
  endfunction

  function automatic mlp_vec_t pack(input int f[$]);
    mlp_vec_t r = '0;
    for (int k = 0; k < f.size(); k++) r = r | (mlp_vec_t'(f[k]) << (k * ACT_W));
    return r;
  endfunction

  // Frame-level model: completed frames wait in exp_q in arrival order; at
  // most two can be held, and the head is what the output must show.
  mlp_vec_t         exp_q[$];
  int               cur_q[$];
  bit               dropping = 1'b0;
  bit               exp_es = 1'b0, exp_el = 1'b0;
  logic [CNT_W-1:0] exp_cnt = '0;
  mlp_vec_t         out_log[$];
  int               es_seen = 0, el_seen = 0;
  bit               mon_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur_q.delete();
      dropping = 1'b0;
      exp_es   = 1'b0;
      exp_el   = 1'b0;
      exp_cnt  = '0;
    end else begin
      bit can_accept;
      can_accept = exp_q.size() < 2;
      exp_es = 1'b0;
      exp_el = 1'b0;
      if (exp_q.size() > 0 && m_ready) begin
        void'(exp_q.pop_front());
        exp_cnt++;
      end
      if (s_valid && can_accept) begin
        if (dropping) begin
          if (s_last) dropping = 1'b0;
        end else begin
          cur_q.push_back(quant(int'(s_data)));
          if (s_last) begin
            if (cur_q.size() == N_FEAT) exp_q.push_back(pack(cur_q));
            else exp_es = 1'b1;
            cur_q.delete();
          end else if (cur_q.size() == N_FEAT) begin
            exp_el   = 1'b1;
            dropping = 1'b1;
            cur_q.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("m_valid", m_valid, exp_q.size() > 0);
      checkOutput("s_ready", s_ready, rst_n && exp_q.size() < 2);
      checkOutput("err_short", err_short, exp_es);
      checkOutput("err_long", err_long, exp_el);
      checkOutput("frame_cnt", frame_cnt, exp_cnt);
      if (exp_q.size() > 0) checkOutput("m_inp", m_inp, exp_q[0]);
      if (m_valid && m_ready) out_log.push_back(m_inp);
      if (err_short) es_seen++;
      if (err_long) el_seen++;
    end
  end

  task automatic applyStimulus(input logic [IN_W-1:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 200) begin
        checkOutput("s_ready timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic applyFrame(input logic [47:0] bytes);
    for (int k = 0; k < N_FEAT; k++) applyStimulus(bytes[k*8 +: 8], k == N_FEAT - 1);
  endtask

  task automatic drain();
    for (int i = 0; i <= 100; i++) begin
      if (exp_q.size() == 0) break;
      if (i == 100) checkOutput("drain timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [47:0] FRAME_A = 48'h605040302010;
  localparam logic [47:0] FRAME_B = 48'h00FFF8F70807;
  localparam logic [47:0] FRAME_C = 48'h203040506070;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, es0, el0, o0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset m_valid", m_valid, 0);
    checkOutput("reset m_inp", m_inp, 0);
    checkOutput("reset frame_cnt", frame_cnt, 0);
    checkOutput("reset s_ready", s_ready, 0);
    checkOutput("reset err_short", err_short, 0);
    checkOutput("reset err_long", err_long, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    $display("[TB] test 1: basic frame");
    applyFrame(FRAME_A);
    checkOutput("t1 latency m_valid", m_valid, 1);
    drain();
    checkOutput("t1 m_inp", out_log[$], 24'h654321);
    checkOutput("t1 frame_cnt", frame_cnt, 1);

    $display("[TB] test 2: quantize corners");
    checkOutput("model quant 0xF8", quant(8'hF8), 15);
    applyFrame(FRAME_B);
    drain();
    checkOutput("t2 m_inp", out_log[$], 24'h0FFF10);
    tq_in = 8'h07; #1;
    checkOutput("trunc 0x07", tq_out, 0);
    tq_in = 8'hF8; #1;
    checkOutput("trunc 0xF8", tq_out, 15);
    tq_in = 8'h1F; #1;
    checkOutput("trunc 0x1F", tq_out, 1);
    @(posedge clk); #1;

    $display("[TB] test 3: back-pressure with three frames");
    m_ready = 1'b0;
    applyFrame(FRAME_A);
    applyFrame(FRAME_B);
    fork
      applyFrame(FRAME_C);
      begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t3 s_ready held", s_ready, 0);
        checkOutput("t3 m_valid held", m_valid, 1);
        checkOutput("t3 m_inp held", m_inp, 24'h654321);
        m_ready = 1'b1;
      end
    join
    drain();
    n = out_log.size();
    checkOutput("t3 order 1", out_log[n-3], 24'h654321);
    checkOutput("t3 order 2", out_log[n-2], 24'h0FFF10);
    checkOutput("t3 order 3", out_log[n-1], 24'h234567);
    checkOutput("t3 frame_cnt", frame_cnt, 5);

    $display("[TB] test 4: short frame");
    es0 = es_seen;
    o0  = out_log.size();
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h20, 1'b0);
    applyStimulus(8'h30, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4 err_short pulses", es_seen - es0, 1);
    checkOutput("t4 no output", out_log.size() - o0, 0);
    applyFrame(FRAME_A);
    drain();
    checkOutput("t4 recovery m_inp", out_log[$], 24'h654321);

    $display("[TB] test 5: long frame");
    el0 = el_seen;
    o0  = out_log.size();
    for (int k = 1; k <= 8; k++) applyStimulus(IN_W'(k * 16), k == 8);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5 err_long pulses", el_seen - el0, 1);
    checkOutput("t5 no output", out_log.size() - o0, 0);
    applyFrame(FRAME_C);
    drain();
    checkOutput("t5 recovery m_inp", out_log[$], 24'h234567);

    $display("[TB] test 6: reset mid-frame");
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h20, 1'b0);
    applyStimulus(8'h30, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6 m_valid", m_valid, 0);
    checkOutput("t6 m_inp", m_inp, 0);
    checkOutput("t6 frame_cnt", frame_cnt, 0);
    checkOutput("t6 s_ready", s_ready, 0);
    checkOutput("t6 err_short", err_short, 0);
    rst_n = 1'b1;
    es0 = es_seen;
    applyFrame(FRAME_A);
    drain();
    checkOutput("t6 m_inp after", out_log[$], 24'h654321);
    checkOutput("t6 frame_cnt after", frame_cnt, 1);
    checkOutput("t6 no error", es_seen - es0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
